// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner. Inputs are captured once per
// frame into shadow registers so a whole scan always shows one coherent value.
module seg7_scan #(
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic        clkin,
  input  logic        clr,
  input  logic        clk_1kHz,
  input  logic        clk_1Hz,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  input  logic [3:0]  blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame
);

  localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic        prev_1k;
  logic        tick;
  logic        snap;
  logic [1:0]  idx;
  logic [1:0]  idx_next;

  logic [15:0] sh_value;
  logic [3:0]  sh_dp;
  logic        sh_blank_lz;
  logic [3:0]  sh_blink;

  logic [15:0] value_nx;
  logic [3:0]  dp_nx;
  logic        blank_lz_nx;
  logic [3:0]  blink_nx;

  logic [3:0]  nib_zero;
  logic [3:0]  lz_mask;
  logic [3:0]  nib;
  logic        lz_off;
  logic        blink_off;
  logic        visible;
  logic [6:0]  seg_lit;
  logic [3:0]  an_lit;
  logic        dp_lit;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] font_low(input logic [3:0] n);
    logic [6:0] code;
    case (n)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      default: code = 7'h0E;
    endcase
    return code;
  endfunction

  always_comb begin
    tick     = clk_1kHz & ~prev_1k;
    snap     = tick & (idx == 2'd3);
    idx_next = idx + 2'd1;
  end

  // On the snapshot edge the display must already reflect the new inputs,
  // so the decode path looks through the shadow registers to their next value.
  always_comb begin
    value_nx    = snap ? value    : sh_value;
    dp_nx       = snap ? dp       : sh_dp;
    blank_lz_nx = snap ? blank_lz : sh_blank_lz;
    blink_nx    = snap ? blink    : sh_blink;
  end

  always_comb begin
    nib_zero[0] = (value_nx[3:0]   == 4'h0);
    nib_zero[1] = (value_nx[7:4]   == 4'h0);
    nib_zero[2] = (value_nx[11:8]  == 4'h0);
    nib_zero[3] = (value_nx[15:12] == 4'h0);
    lz_mask[0]  = 1'b0;
    lz_mask[1]  = nib_zero[3] & nib_zero[2] & nib_zero[1];
    lz_mask[2]  = nib_zero[3] & nib_zero[2];
    lz_mask[3]  = nib_zero[3];
  end

  always_comb begin
    nib       = value_nx[{idx_next, 2'b00} +: 4];
    lz_off    = blank_lz_nx & lz_mask[idx_next];
    blink_off = blink_nx[idx_next] & ~clk_1Hz;
    visible   = ~(lz_off | blink_off);
    seg_lit   = visible ? ~font_low(nib) : 7'h00;
    an_lit    = visible ? (4'b0001 << idx_next) : 4'h0;
    dp_lit    = visible & dp_nx[idx_next];
    an_d      = (AN_ACTIVE_LOW != 0)  ? ~an_lit  : an_lit;
    seg_d     = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
    dp_d      = (SEG_ACTIVE_LOW != 0) ? ~dp_lit  : dp_lit;
  end

  always_ff @(posedge clkin or posedge clr) begin
    if (clr) begin
      prev_1k <= 1'b0;
      idx     <= 2'd0;
      frame   <= 1'b0;
    end else begin
      prev_1k <= clk_1kHz;
      frame   <= snap;
      if (tick) idx <= idx_next;
    end
  end

  always_ff @(posedge clkin or posedge clr) begin
    if (clr) begin
      sh_value    <= 16'h0000;
      sh_dp       <= 4'h0;
      sh_blank_lz <= 1'b0;
      sh_blink    <= 4'h0;
    end else if (snap) begin
      sh_value    <= value;
      sh_dp       <= dp;
      sh_blank_lz <= blank_lz;
      sh_blink    <= blink;
    end
  end

  always_ff @(posedge clkin or posedge clr) begin
    if (clr) begin
      an   <= AN_OFF;
      seg  <= SEG_OFF;
      dp_n <= DP_OFF;
    end else if (tick) begin
      an   <= an_d;
      seg  <= seg_d;
      dp_n <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: the driver predicts each scan slot from a
// digit-level model; a monitor compares whenever the display updates.
module tb_seg7_scan;

  logic        clkin = 1'b0;
  logic        clr;
  logic        clk_1kHz;
  logic        clk_1Hz;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [3:0]  blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame;

  seg7_scan #(.SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clkin(clkin), .clr(clr), .clk_1kHz(clk_1kHz), .clk_1Hz(clk_1Hz),
    .value(value), .dp(dp), .blank_lz(blank_lz), .blink(blink),
    .an(an), .seg(seg), .dp_n(dp_n), .frame(frame)
  );

  always #5 clkin = ~clkin;

  localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       frame;
    logic       chk;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model: which digit is on screen and what was latched at the last frame.
  int          m_digit;
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic [3:0]  m_blink;
  logic        m_blz;
  bit          m_synced;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digit  = 0;
    m_value  = 16'h0;
    m_dp     = 4'h0;
    m_blink  = 4'h0;
    m_blz    = 1'b0;
    m_synced = 0;
  endtask

  task automatic push_expected();
    exp_t e;
    int   k;
    bit   vis;
    int   nibble;
    e.frame = 1'b0;
    m_digit = (m_digit + 1) % 4;
    if (m_digit == 0) begin
      m_value  = value;
      m_dp     = dp;
      m_blink  = blink;
      m_blz    = blank_lz;
      m_synced = 1;
      e.frame  = 1'b1;
    end
    k      = m_digit;
    nibble = (int'(m_value) >> (4 * k)) % 16;
    vis    = 1;
    if (m_blz && k > 0 && (int'(m_value) >> (4 * k)) == 0) vis = 0;
    if (m_blink[k] && !clk_1Hz) vis = 0;
    e.an   = vis ? (4'hF ^ (4'b0001 << k)) : 4'hF;
    e.seg  = vis ? FONT[nibble] : 7'h7F;
    e.dp_n = !(vis && m_dp[k]);
    e.chk  = m_synced;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic scan_tick(input int hi, input int lo);
    @(negedge clkin);
    push_expected();
    clk_1kHz = 1'b1;
    cyc(hi);
    clk_1kHz = 1'b0;
    cyc(lo);
  endtask

  // Monitor: detects display updates from the scan strobe it observes.
  logic mon_prev = 1'b0;
  bit   mon_tick;
  bit   mon_rst;
  bit   have_last = 0;
  exp_t last;
  exp_t got;

  always @(posedge clkin) begin
    if (clr) begin
      mon_rst  = 1;
      mon_tick = 0;
      mon_prev = 1'b0;
    end else begin
      mon_rst  = 0;
      mon_tick = clk_1kHz && !mon_prev;
      mon_prev = clk_1kHz;
    end
    #1;
    if (mon_rst) begin
      have_last = 0;
      check("frame_in_reset", frame, 1'b0);
    end else if (mon_tick) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_update: an=%b seg=%h with no prediction queued", an, seg);
      end else begin
        got = q.pop_front();
        check("frame_on_tick", frame, got.frame);
        if (got.chk) begin
          check("an", an, got.an);
          check("seg", seg, got.seg);
          check("dp_n", dp_n, got.dp_n);
          last      = got;
          have_last = 1;
        end
      end
    end else begin
      check("frame_idle", frame, 1'b0);
      if (have_last) begin
        check("an_hold", an, last.an);
        check("seg_hold", seg, last.seg);
        check("dp_n_hold", dp_n, last.dp_n);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    clr      = 1'b1;
    clk_1kHz = 1'b0;
    clk_1Hz  = 1'b1;
    value    = 16'h0;
    dp       = 4'h0;
    blank_lz = 1'b0;
    blink    = 4'h0;
    model_reset();
    cyc(3);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp_n", dp_n, 1'b1);
    check("rst_frame", frame, 1'b0);
    clr = 1'b0;
    cyc(2);

    // 1234 stepping through all four digits, 4-cycle half periods.
    value = 16'h1234;
    repeat (8) scan_tick(4, 4);

    // Leading-zero blanking.
    value    = 16'h0070;
    blank_lz = 1'b1;
    repeat (8) scan_tick(4, 4);

    // Mid-frame input change must wait for the next snapshot.
    value    = 16'h1234;
    blank_lz = 1'b0;
    repeat (4) scan_tick(2, 3);
    while (m_digit != 1) scan_tick(2, 3);
    value = 16'h5678;
    repeat (7) scan_tick(2, 3);

    // Blink with decimal point on digit 0.
    blink = 4'b0001;
    dp    = 4'b0001;
    while (m_digit != 3) scan_tick(2, 2);
    scan_tick(2, 2);
    clk_1Hz = 1'b0;
    repeat (4) scan_tick(2, 2);
    clk_1Hz = 1'b1;
    repeat (4) scan_tick(2, 2);

    // Strobe held high: a single update, then frozen outputs.
    @(negedge clkin);
    push_expected();
    clk_1kHz = 1'b1;
    cyc(100);
    clk_1kHz = 1'b0;
    cyc(3);

    // Asynchronous reset between clock edges, mid-frame.
    scan_tick(2, 2);
    @(negedge clkin);
    #2 clr = 1'b1;
    #1;
    check("async_rst_an", an, 4'hF);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_dp_n", dp_n, 1'b1);
    check("async_rst_frame", frame, 1'b0);
    cyc(3);
    q.delete();
    model_reset();
    clr = 1'b0;
    cyc(2);
    repeat (9) scan_tick(3, 2);

    // Randomized traffic.
    for (int i = 0; i < 220; i++) begin
      value    = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
      dp       = 4'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
      blink    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      clk_1Hz  = 1'($urandom_range(0, 1));
      scan_tick($urandom_range(1, 4), $urandom_range(1, 4));
    end

    cyc(5);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending updates, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
